ibex_lsm_mem_masker: RTL
========================

Name: ibex_lsm_mem_masker

Overview:
- Sits between the load/store unit and the data memory port.
- Masks store data and unmasks load data with a per-word mask from the combinational LSM generator.
- Drives the generator's address input with the word-aligned request address and samples the returned mask at grant.
- Keeps a small FIFO of captured masks, so each response is unmasked with the mask of its own request, even if the seed changes while requests are outstanding.

Parameters:
- MaxOutstanding, 2, depth of the outstanding-transaction FIFO (1..4).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- lsu_req_i  input  1  LSU request valid
- lsu_gnt_o  output  1  request accepted
- lsu_we_i  input  1  1=store, 0=load
- lsu_be_i  input  4  byte enables
- lsu_addr_i  input  32  byte address
- lsu_wdata_i  input  32  plaintext store data
- lsu_rvalid_o  output  1  response valid
- lsu_rdata_o  output  32  unmasked load data
- lsu_err_o  output  1  response bus error
- data_req_o  output  1  memory request
- data_gnt_i  input  1  memory grant
- data_we_o  output  1  memory write enable
- data_be_o  output  4  memory byte enables
- data_addr_o  output  32  memory address
- data_wdata_o  output  32  masked store data
- data_rvalid_i  input  1  memory response valid
- data_rdata_i  input  32  masked memory read data
- data_err_i  input  1  memory bus error
- lsm_addr_o  output  32  address to the LSM generator
- lsm_mask_i  input  32  mask from the LSM generator
- protocol_err_o  output  1  one-cycle pulse: response arrived with the FIFO empty

Behaviour:
- Reset (async, rst_ni low):
  - FIFO count, pointers and entries cleared to 0.
  - protocol_err_o = 0.
  - Combinational outputs follow the rules below with count=0.
- lsm_addr_o = {lsu_addr_i[31:2], 2'b00}.
  - The mask is per word, so byte lanes stay consistent across sub-word accesses.
- full = (count == MaxOutstanding), computed from the registered count only.
  - No same-cycle bypass: a pop in a full cycle does not allow a request in that cycle.
- Request path, combinational from the LSU inputs:
  - data_req_o = lsu_req_i & ~full.
  - data_we_o, data_be_o and data_addr_o pass lsu_we_i, lsu_be_i and lsu_addr_i through unchanged.
  - data_wdata_o = lsu_wdata_i ^ lsm_mask_i.
- Grant: lsu_gnt_o = data_gnt_i & data_req_o.
  - On grant, push {lsu_we_i, lsm_mask_i} at the write pointer.
  - Write pointer advances modulo MaxOutstanding.
- Response, when data_rvalid_i is high and count > 0:
  - Pop the head entry.
  - lsu_rvalid_o = 1, lsu_err_o = data_err_i.
  - lsu_rdata_o = data_rdata_i ^ head.mask for loads; 32'h0 for stores.
- Response with count == 0:
  - lsu_rvalid_o = 0, response dropped.
  - protocol_err_o registered high for exactly one cycle.
- Outside valid responses, lsu_rdata_o = 0 and lsu_err_o = 0.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo MaxOutstanding; count is never more than MaxOutstanding or less than 0.
- Masks are taken only at grant. Later changes to lsm_mask_i (seed update) do not affect queued entries.
- Errored load: data is still unmasked, error flag passes through.
- Reset mid-transaction: queue discarded. Any later stale response counts as the empty case (protocol_err_o pulse).

Optional Feature:
- Macro IBEX_LSM_RUNTIME_DISABLE_EN.
- Defined:
  - Adds input lsm_en_i (1 bit).
  - Effective mask = lsm_en_i ? lsm_mask_i : 32'h0, used for both data_wdata_o and the FIFO push.
  - lsm_en_i is sampled per transaction at grant; toggling it while requests are outstanding does not affect queued entries.
- Undefined: port absent; masking always active.

Test Plan:
- Store: lsu_addr_i=0x0000_1006, lsu_wdata_i=0x1234_5678, lsm_mask_i=0xA5A5_0F0F, grant in the same cycle -> data_wdata_o=0xB791_5977, lsm_addr_o=0x0000_1004; response -> lsu_rvalid_o=1, lsu_rdata_o=0.
- Load, mask changed before response: mask 0x0F0F_F0F0 at grant, changed to 0xFFFF_FFFF before rvalid; data_rdata_i=0x0F0F_F0F0 -> lsu_rdata_o=0x0000_0000.
- Back-to-back loads with masks M1=0x1111_1111 and M2=0x2222_2222; responses 0x1111_1111 then 0x2222_2222 -> lsu_rdata_o 0, 0 in order.
- Full stall, MaxOutstanding=2:
  - Two grants without responses -> third request sees data_req_o=0, lsu_gnt_o=0.
  - rvalid in that cycle -> data_req_o rises the next cycle.
- Spurious response: data_rvalid_i with FIFO empty (also after async reset with two requests pending) -> lsu_rvalid_o=0, protocol_err_o high for 1 cycle.
- Feature defined, lsm_en_i=0: data_wdata_o equals lsu_wdata_i; a load granted with lsm_en_i=0 and answered after lsm_en_i=1 returns data_rdata_i unmodified.

Source files
------------

// File: rtl/ibex_lsm_mem_masker.sv
// ibex_lsm_mem_masker: masks stores and unmasks loads with a per-request mask FIFO
// IBEX_LSM_RUNTIME_DISABLE_EN adds lsm_en_i to gate the mask per transaction.
module ibex_lsm_mem_masker #(
    parameter int MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
`ifdef IBEX_LSM_RUNTIME_DISABLE_EN
    input  logic        lsm_en_i,
`endif
    input  logic        lsu_req_i,
    output logic        lsu_gnt_o,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i,
    output logic [31:0] lsm_addr_o,
    input  logic [31:0] lsm_mask_i,
    output logic        protocol_err_o
);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);

    logic [CntW-1:0] cnt_q;
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [32:0]     fifo_q [MaxOutstanding];
    logic            protocol_err_q;
    logic            full, push, pop;
    logic [31:0]     eff_mask;
    logic [32:0]     head;

    function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

`ifdef IBEX_LSM_RUNTIME_DISABLE_EN
    assign eff_mask = lsm_en_i ? lsm_mask_i : 32'h0;
`else
    assign eff_mask = lsm_mask_i;
`endif

    // mask is per word so sub-word accesses see consistent byte lanes
    assign lsm_addr_o   = {lsu_addr_i[31:2], 2'b00};
    assign full         = cnt_q == CntW'(MaxOutstanding);
    assign data_req_o   = lsu_req_i & ~full;
    assign data_we_o    = lsu_we_i;
    assign data_be_o    = lsu_be_i;
    assign data_addr_o  = lsu_addr_i;
    assign data_wdata_o = lsu_wdata_i ^ eff_mask;
    assign lsu_gnt_o    = data_gnt_i & data_req_o;
    assign push         = lsu_gnt_o;
    assign pop          = data_rvalid_i & (cnt_q != '0);
    assign head         = fifo_q[rptr_q];
    assign lsu_rvalid_o = pop;
    assign lsu_err_o    = pop & data_err_i;
    assign lsu_rdata_o  = (pop & ~head[32]) ? data_rdata_i ^ head[31:0] : 32'h0;
    assign protocol_err_o = protocol_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q          <= '0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            protocol_err_q <= 1'b0;
            for (int i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
        end else begin
            cnt_q          <= cnt_q + CntW'(push) - CntW'(pop);
            protocol_err_q <= data_rvalid_i & (cnt_q == '0);
            if (push) begin
                fifo_q[wptr_q] <= {lsu_we_i, eff_mask};
                wptr_q         <= inc(wptr_q);
            end
            if (pop) rptr_q <= inc(rptr_q);
        end
    end
endmodule
